slice_config_loader: RTL and testbench

- Upstream feeder for the slice configuration chain (config_in / config_en / config_out).
- Accepts configuration words on a valid/ready stream and serialises them LSB-first into the chain, one bit per clk cycle while config_en is high.
- Counts exactly CHAIN_LEN bits, then signals completion.
- The slice's config_clk is tied to the same clk; this block controls the chain only through config_en.

---
 rtl/slice_config_loader_if.sv | 11 +
 rtl/slice_config_loader.sv | 142 ++++++++++++++
 tb/tb_slice_config_loader.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_config_loader_if.sv
// Valid/ready stream carrying configuration words into slice_config_loader.
interface slice_config_loader_if #(
    parameter int unsigned WORD_W = 8
);
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/slice_config_loader.sv
// Serialises stream words LSB-first into the slice configuration chain, CHAIN_LEN bits per load.
// Define SLICE_CONFIG_READBACK_EN to add rb_data_o/rb_valid_o capture of the chain tail.
module slice_config_loader #(
    parameter int unsigned CHAIN_LEN = 128,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 GSR,
    input  logic                 start_i,
    slice_config_loader_if.slave s_if,
    output logic                 config_in_o,
    output logic                 config_en_o,
    input  logic                 config_out_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 loaded_o,
    output logic [CNT_W-1:0]     bit_cnt_o
`ifdef SLICE_CONFIG_READBACK_EN
    ,
    output logic [WORD_W-1:0]    rb_data_o,
    output logic                 rb_valid_o
`endif
);

    localparam int unsigned WbW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

    state_e            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WbW-1:0]    word_bit_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic              config_in_q;
    logic              config_en_q;
    logic              done_q;
    logic              loaded_q;
    logic              last_bit;
    logic              word_last;

    assign last_bit  = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
    assign word_last = (word_bit_q == WbW'(WORD_W - 1));

    always_ff @(posedge clk or posedge GSR) begin
        if (GSR) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            word_bit_q  <= '0;
            bit_cnt_q   <= '0;
            config_in_q <= 1'b0;
            config_en_q <= 1'b0;
            done_q      <= 1'b0;
            loaded_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q   <= StLoad;
                        bit_cnt_q <= '0;
                        loaded_q  <= 1'b0;
                    end
                end
                StLoad: begin
                    // Bit 0 goes straight to the output register; the rest wait in shreg.
                    if (s_if.s_valid) begin
                        shreg_q     <= s_if.s_data >> 1;
                        config_in_q <= s_if.s_data[0];
                        config_en_q <= 1'b1;
                        word_bit_q  <= '0;
                        state_q     <= StShift;
                    end
                end
                StShift: begin
                    bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                    word_bit_q <= word_bit_q + WbW'(1);
                    if (last_bit) begin
                        state_q     <= StDone;
                        config_en_q <= 1'b0;
                        done_q      <= 1'b1;
                        loaded_q    <= 1'b1;
                    end else if (word_last) begin
                        state_q     <= StLoad;
                        config_en_q <= 1'b0;
                    end else begin
                        config_in_q <= shreg_q[0];
                        shreg_q     <= shreg_q >> 1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign s_if.s_ready = (state_q == StLoad);
    assign busy_o       = (state_q == StLoad) || (state_q == StShift);
    assign config_in_o  = config_in_q;
    assign config_en_o  = config_en_q;
    assign done_o       = done_q;
    assign loaded_o     = loaded_q;
    assign bit_cnt_o    = bit_cnt_q;

`ifdef SLICE_CONFIG_READBACK_EN
    logic [WORD_W-1:0] rb_shreg_q;
    logic [WORD_W-1:0] rb_next;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;

    // New bits enter at the MSB so the earliest captured bit ends up in bit 0.
    assign rb_next = (rb_shreg_q >> 1) | (WORD_W'(config_out_i) << (WORD_W - 1));

    always_ff @(posedge clk or posedge GSR) begin
        if (GSR) begin
            rb_shreg_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (config_en_q) begin
                rb_shreg_q <= rb_next;
                if (last_bit || word_last) begin
                    // Right-align a short final word; vacated upper bits fill with 0.
                    rb_data_q  <= rb_next >> (WbW'(WORD_W - 1) - word_bit_q);
                    rb_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rb_data_o  = rb_data_q;
    assign rb_valid_o = rb_valid_q;
`else
    logic unused_config_out;
    assign unused_config_out = config_out_i;
`endif

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed bench for slice_config_loader: a 24-bit and a 20-bit chain, scoreboarded config_in bits.
module tb_slice_config_loader;

    logic        clk = 1'b0;
    logic        gsr = 1'b1;
    logic        a_start, b_start;
    logic        a_cin, a_cen, a_cout, a_busy, a_done, a_loaded;
    logic        b_cin, b_cen, b_cout, b_busy, b_done, b_loaded;
    logic [15:0] a_cnt, b_cnt;
    logic [23:0] chain = '0;

    slice_config_loader_if #(.WORD_W(8)) a_if ();
    slice_config_loader_if #(.WORD_W(8)) b_if ();

`ifdef SLICE_CONFIG_READBACK_EN
    logic [7:0] a_rb_data, b_rb_data;
    logic       a_rb_valid, b_rb_valid;
    logic [7:0] rb_exp[$];
    int         a_rb_cnt = 0;
    bit         rb_on = 1'b0;
    logic       a_rb_prev = 1'b0;
`endif

    slice_config_loader #(.CHAIN_LEN(24), .WORD_W(8), .CNT_W(16)) u_dut_a (
        .clk          (clk),
        .GSR          (gsr),
        .start_i      (a_start),
        .s_if         (a_if),
        .config_in_o  (a_cin),
        .config_en_o  (a_cen),
        .config_out_i (a_cout),
        .busy_o       (a_busy),
        .done_o       (a_done),
        .loaded_o     (a_loaded),
        .bit_cnt_o    (a_cnt)
`ifdef SLICE_CONFIG_READBACK_EN
        ,
        .rb_data_o    (a_rb_data),
        .rb_valid_o   (a_rb_valid)
`endif
    );

    slice_config_loader #(.CHAIN_LEN(20), .WORD_W(8), .CNT_W(16)) u_dut_b (
        .clk          (clk),
        .GSR          (gsr),
        .start_i      (b_start),
        .s_if         (b_if),
        .config_in_o  (b_cin),
        .config_en_o  (b_cen),
        .config_out_i (b_cout),
        .busy_o       (b_busy),
        .done_o       (b_done),
        .loaded_o     (b_loaded),
        .bit_cnt_o    (b_cnt)
`ifdef SLICE_CONFIG_READBACK_EN
        ,
        .rb_data_o    (b_rb_data),
        .rb_valid_o   (b_rb_valid)
`endif
    );

    always #5 clk = ~clk;

    // Model of the downstream 24-bit chain sharing clk; the tail feeds config_out.
    always @(posedge clk) if (a_cen) chain <= {a_cin, chain[23:1]};
    assign a_cout = chain[0];
    assign b_cout = 1'b0;

    int   n_vec = 0, n_err = 0, cyc_n = 0;
    logic exp_a[$], exp_b[$];
    int   a_en_cnt = 0, a_bursts = 0, a_done_cnt = 0, a_first_rise = -1, a_last_en = 0;
    int   b_en_cnt = 0, b_done_cnt = 0;
    logic a_prev = 1'b0;
    logic [3:0] b_last4 = '0;
    bit   b_late = 1'b0;
    int   en0, bu0, d0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample/score at negedge, return 1 time unit after the next posedge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (a_cen) begin
            a_en_cnt++;
            a_last_en = cyc_n;
            if (!a_prev) begin
                a_bursts++;
                if (a_first_rise < 0) a_first_rise = cyc_n;
            end
            if (exp_a.size() == 0) chk("a_en_unexpected", 32'(a_cen), 32'd0);
            else chk("a_config_in", 32'(a_cin), 32'(exp_a.pop_front()));
        end
        a_prev = a_cen;
        if (a_done) begin
            a_done_cnt++;
            chk("a_cnt_at_done", 32'(a_cnt), 32'd24);
        end
        if (b_cen) begin
            b_en_cnt++;
            b_last4 = {b_last4[2:0], b_cin};
            if (exp_b.size() == 0) chk("b_en_unexpected", 32'(b_cen), 32'd0);
            else chk("b_config_in", 32'(b_cin), 32'(exp_b.pop_front()));
        end
        if (b_done) begin
            b_done_cnt++;
            chk("b_cnt_at_done", 32'(b_cnt), 32'd20);
        end
        if (b_late) chk("b_ready_after_last", 32'(b_if.s_ready), 32'd0);
`ifdef SLICE_CONFIG_READBACK_EN
        if (a_rb_valid) begin
            a_rb_cnt++;
            if (a_rb_prev) chk("rb_valid_width", 32'(a_rb_valid), 32'd0);
            if (rb_on) begin
                if (rb_exp.size() == 0) chk("rb_unexpected", 32'(a_rb_valid), 32'd0);
                else chk("rb_data", 32'(a_rb_data), 32'(rb_exp.pop_front()));
            end
        end
        a_rb_prev = a_rb_valid;
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [7:0] w, input int nb);
        bit r = 1'b0;
        if (!sel) begin
            a_if.s_data  = w;
            a_if.s_valid = 1'b1;
            for (int i = 0; i < nb; i++) exp_a.push_back(w[i]);
        end else begin
            b_if.s_data  = w;
            b_if.s_valid = 1'b1;
            for (int i = 0; i < nb; i++) exp_b.push_back(w[i]);
        end
        for (int n = 0; n < 100; n++) begin
            r = sel ? b_if.s_ready : a_if.s_ready;
            cyc();
            if (r) break;
        end
        chk(sel ? "b_accept" : "a_accept", 32'(r), 32'd1);
    endtask

    // Returns in the DONE cycle (done high), before its negedge is scored.
    task automatic wait_done(input bit sel);
        for (int n = 0; n < 200; n++) begin
            if (sel ? b_done : a_done) break;
            cyc();
        end
        chk(sel ? "b_done_seen" : "a_done_seen", 32'(sel ? b_done : a_done), 32'd1);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        cyc();
        b_start = 1'b0;
        a_start = 1'b0;
    endtask

    initial begin
        a_start = 1'b0;
        b_start = 1'b0;
        a_if.s_valid = 1'b0;
        a_if.s_data  = '0;
        b_if.s_valid = 1'b0;
        b_if.s_data  = '0;
        cyc();
        cyc();
        chk("rst_a_en", 32'(a_cen), 32'd0);
        chk("rst_a_in", 32'(a_cin), 32'd0);
        chk("rst_a_ready", 32'(a_if.s_ready), 32'd0);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_done", 32'(a_done), 32'd0);
        chk("rst_a_loaded", 32'(a_loaded), 32'd0);
        chk("rst_a_cnt", 32'(a_cnt), 32'd0);
        chk("rst_b_cnt", 32'(b_cnt), 32'd0);
        gsr = 1'b0;
        cyc();

        // 24-bit load of A5, 3C, F0 with s_valid kept high.
        en0 = a_en_cnt; bu0 = a_bursts; d0 = a_done_cnt; a_first_rise = -1;
        pulse_start(1'b0);
        chk("t1_busy", 32'(a_busy), 32'd1);
        chk("t1_ready", 32'(a_if.s_ready), 32'd1);
        chk("t1_cnt0", 32'(a_cnt), 32'd0);
        send(1'b0, 8'hA5, 8);
        send(1'b0, 8'h3C, 8);
        send(1'b0, 8'hF0, 8);
        a_if.s_valid = 1'b0;
        wait_done(1'b0);
        chk("t1_loaded_in_done", 32'(a_loaded), 32'd1);
        cyc();
        cyc();
        cyc();
        chk("t1_en_cycles", 32'(a_en_cnt - en0), 32'd24);
        chk("t1_bursts", 32'(a_bursts - bu0), 32'd3);
        chk("t1_span", 32'(a_last_en - a_first_rise), 32'd25);
        chk("t1_done_pulses", 32'(a_done_cnt - d0), 32'd1);
        chk("t1_bits_left", 32'(exp_a.size()), 32'd0);
        chk("t1_loaded", 32'(a_loaded), 32'd1);
        chk("t1_idle_busy", 32'(a_busy), 32'd0);

        // 20-bit chain: last word only contributes its low 4 bits.
        pulse_start(1'b1);
        chk("t2_loaded_cleared", 32'(b_loaded), 32'd0);
        send(1'b1, 8'hFF, 8);
        send(1'b1, 8'hFF, 8);
        send(1'b1, 8'h0F, 4);
        b_if.s_data = 8'h77;
        b_late = 1'b1;
        wait_done(1'b1);
        for (int i = 0; i < 4; i++) cyc();
        b_late = 1'b0;
        b_if.s_valid = 1'b0;
        chk("t2_en_cycles", 32'(b_en_cnt), 32'd20);
        chk("t2_last4", 32'(b_last4), 32'hF);
        chk("t2_done_pulses", 32'(b_done_cnt), 32'd1);
        chk("t2_bits_left", 32'(exp_b.size()), 32'd0);
        chk("t2_loaded", 32'(b_loaded), 32'd1);

        // Stall in LOAD, stray start during SHIFT, start coinciding with DONE.
        en0 = a_en_cnt; d0 = a_done_cnt;
        pulse_start(1'b0);
        send(1'b0, 8'h5A, 8);
        a_if.s_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (a_if.s_ready) break;
            cyc();
        end
        chk("t3_in_load", 32'(a_if.s_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_stall_en", 32'(a_cen), 32'd0);
            chk("t3_stall_cnt", 32'(a_cnt), 32'd8);
            cyc();
        end
        send(1'b0, 8'hC3, 8);
        chk("t3_resume_en", 32'(a_cen), 32'd1);
        chk("t3_resume_cnt", 32'(a_cnt), 32'd8);
        cyc();
        cyc();
        pulse_start(1'b0);
        chk("t4_cnt_continues", 32'(a_cnt), 32'd11);
        chk("t4_still_shift", 32'(a_cen), 32'd1);
        send(1'b0, 8'h81, 8);
        a_if.s_valid = 1'b0;
        wait_done(1'b0);
        pulse_start(1'b0);
        chk("t4_start_in_done_busy", 32'(a_busy), 32'd0);
        chk("t4_start_in_done_ready", 32'(a_if.s_ready), 32'd0);
        cyc();
        chk("t4_done_pulses", 32'(a_done_cnt - d0), 32'd1);
        chk("t4_en_cycles", 32'(a_en_cnt - en0), 32'd24);
        chk("t4_bits_left", 32'(exp_a.size()), 32'd0);

        // Asynchronous reset at bit_cnt 5, then a clean reload.
        pulse_start(1'b0);
        send(1'b0, 8'h96, 8);
        for (int n = 0; n < 20; n++) begin
            if (a_cnt == 16'd5) break;
            cyc();
        end
        chk("t5_reached_5", 32'(a_cnt), 32'd5);
        #1 gsr = 1'b1;
        #1;
        chk("t5_rst_en", 32'(a_cen), 32'd0);
        chk("t5_rst_in", 32'(a_cin), 32'd0);
        chk("t5_rst_busy", 32'(a_busy), 32'd0);
        chk("t5_rst_ready", 32'(a_if.s_ready), 32'd0);
        chk("t5_rst_cnt", 32'(a_cnt), 32'd0);
        chk("t5_rst_loaded", 32'(a_loaded), 32'd0);
        exp_a.delete();
        a_if.s_valid = 1'b0;
        cyc();
        gsr = 1'b0;
        cyc();
        en0 = a_en_cnt; d0 = a_done_cnt;
        pulse_start(1'b0);
        send(1'b0, 8'h12, 8);
        send(1'b0, 8'h34, 8);
        send(1'b0, 8'h56, 8);
        a_if.s_valid = 1'b0;
        wait_done(1'b0);
        cyc();
        cyc();
        chk("t5_en_cycles", 32'(a_en_cnt - en0), 32'd24);
        chk("t5_done_pulses", 32'(a_done_cnt - d0), 32'd1);
        chk("t5_loaded", 32'(a_loaded), 32'd1);

`ifdef SLICE_CONFIG_READBACK_EN
        // Second load pushes the first load's bits out of the chain tail.
        pulse_start(1'b0);
        send(1'b0, 8'hA5, 8);
        send(1'b0, 8'h3C, 8);
        send(1'b0, 8'hF0, 8);
        a_if.s_valid = 1'b0;
        wait_done(1'b0);
        cyc();
        cyc();
        rb_exp.push_back(8'hA5);
        rb_exp.push_back(8'h3C);
        rb_exp.push_back(8'hF0);
        d0 = a_rb_cnt;
        rb_on = 1'b1;
        pulse_start(1'b0);
        send(1'b0, 8'h00, 8);
        send(1'b0, 8'h00, 8);
        send(1'b0, 8'h00, 8);
        a_if.s_valid = 1'b0;
        wait_done(1'b0);
        cyc();
        cyc();
        rb_on = 1'b0;
        chk("rb_pulses", 32'(a_rb_cnt - d0), 32'd3);
        chk("rb_left", 32'(rb_exp.size()), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
